// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter that shares one I2C master among NUM_REQ
// requesters. A transaction flows IDLE -> ARB -> LAUNCH -> WAIT -> RESP, and
// every output is driven from a register.
// Optional feature: define I2C_ARBITER_TIMEOUT_EN to build a WAIT watchdog.
// The watchdog completes a stalled transaction with nack=1 after
// TIMEOUT_CYCLES WAIT cycles. Without the macro, WAIT lasts until mst_done.
module i2c_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [8*NUM_REQ-1:0] req_dev,
  input  logic [8*NUM_REQ-1:0] req_reg,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 nack,
  output logic                 busy,
  output logic                 mst_load,
  output logic                 mst_rw,
  output logic [7:0]           mst_dev,
  output logic [7:0]           mst_reg,
  output logic [7:0]           mst_data,
  input  logic                 mst_done,
  input  logic                 mst_nack
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               nack_q, nack_d;
  logic               busy_q, busy_d;
  logic               mst_load_q, mst_load_d;
  logic               mst_rw_q, mst_rw_d;
  logic [7:0]         mst_dev_q, mst_dev_d;
  logic [7:0]         mst_reg_q, mst_reg_d;
  logic [7:0]         mst_data_q, mst_data_d;

  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  logic               timeout;

`ifdef I2C_ARBITER_TIMEOUT_EN
  // The counter holds 0..TIMEOUT_CYCLES-1. The last value marks the final WAIT cycle.
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // Round-robin search: take the first set req bit at or after rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!arb_found && req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    // NOTE: every _d gets a default before the case statement. No path leaves a
    // signal unassigned, so no latches are inferred.
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    nack_d     = 1'b0;
    mst_load_d = 1'b0;
    mst_rw_d   = mst_rw_q;
    mst_dev_d  = mst_dev_q;
    mst_reg_d  = mst_reg_q;
    mst_data_d = mst_data_q;
`ifdef I2C_ARBITER_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (|req) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          // Latch the payload now, so later input changes cannot disturb this transaction.
          idx_d      = arb_idx;
          gnt_d      = NUM_REQ'(1) << arb_idx;
          mst_rw_d   = req_rw[arb_idx];
          mst_dev_d  = req_dev[8*arb_idx +: 8];
          mst_reg_d  = req_reg[8*arb_idx +: 8];
          mst_data_d = req_data[8*arb_idx +: 8];
          state_d    = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        mst_load_d = 1'b1;
        state_d    = S_WAIT;
`ifdef I2C_ARBITER_TIMEOUT_EN
        cnt_d      = '0;
`endif
      end
      S_WAIT: begin
        if (mst_done) begin
          done_d  = NUM_REQ'(1) << idx_q;
          nack_d  = mst_nack;
          state_d = S_RESP;
        end else if (timeout) begin
          done_d  = NUM_REQ'(1) << idx_q;
          nack_d  = 1'b1;
          state_d = S_RESP;
        end
`ifdef I2C_ARBITER_TIMEOUT_EN
        cnt_d = cnt_q + 1'b1;
`endif
      end
      S_RESP: begin
        gnt_d    = '0;
        rr_ptr_d = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers. Reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // therefore update together at the clock edge.
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      nack_q     <= 1'b0;
      busy_q     <= 1'b0;
      mst_load_q <= 1'b0;
      mst_rw_q   <= 1'b0;
      mst_dev_q  <= '0;
      mst_reg_q  <= '0;
      mst_data_q <= '0;
`ifdef I2C_ARBITER_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      busy_q     <= busy_d;
      mst_load_q <= mst_load_d;
      mst_rw_q   <= mst_rw_d;
      mst_dev_q  <= mst_dev_d;
      mst_reg_q  <= mst_reg_d;
      mst_data_q <= mst_data_d;
`ifdef I2C_ARBITER_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign nack     = nack_q;
  assign busy     = busy_q;
  assign mst_load = mst_load_q;
  assign mst_rw   = mst_rw_q;
  assign mst_dev  = mst_dev_q;
  assign mst_reg  = mst_reg_q;
  assign mst_data = mst_data_q;

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: watchdog limit in clk cycles, legal range 16..65535.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 Port clk  in  1  clock.
REQ-005 Port rst  in  1  asynchronous active-high reset.
REQ-006 Port req  in  NUM_REQ  per-requester transaction request, a level held until the matching done pulse.
REQ-007 Port req_rw  in  NUM_REQ  per-requester read/write bit: 1 = read.
REQ-008 Port req_dev  in  8*NUM_REQ  per-requester device address; requester i occupies bits [8i+7:8i].
REQ-009 Port req_reg  in  8*NUM_REQ  per-requester register address, packed the same way.
REQ-010 Port req_data  in  8*NUM_REQ  per-requester write data, packed the same way.
REQ-011 Port gnt  out  NUM_REQ  one-hot grant, high from the ARB exit until the RESP exit.
REQ-012 Port done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-013 Port nack  out  1  status of the completing transaction, valid with done: 1 = NACK or timeout.
REQ-014 Port busy  out  1  high in every state except IDLE.
REQ-015 Port mst_load  out  1  one-cycle start pulse to the I2C master.
REQ-016 Port mst_rw  out  1  read/write bit driven to the I2C master.
REQ-017 Port mst_dev, mst_reg, mst_data  out  8 each  latched fields driven to the I2C master.
REQ-018 Port mst_done  in  1  one-cycle pulse from the master marking the end of a transaction.
REQ-019 Port mst_nack  in  1  master's NACK status, valid with mst_done.

Function
REQ-020 The FSM SHALL have the states IDLE, ARB, LAUNCH, WAIT and RESP; all outputs SHALL be registered.
REQ-021 IDLE: if any req bit is 1, the next state SHALL be ARB; otherwise the FSM SHALL stay in IDLE.
REQ-022 ARB (1 cycle): SHALL select the first set req bit at or after rr_ptr, wrapping modulo NUM_REQ; SHALL latch that requester's index, rw, dev, reg and data; SHALL set gnt; next state LAUNCH.
REQ-023 ARB with req all zero (request withdrawn): SHALL return to IDLE with no grant and no done.
REQ-024 LAUNCH (1 cycle): SHALL assert mst_load for exactly this cycle; next state WAIT.
REQ-025 mst_rw, mst_dev, mst_reg and mst_data SHALL hold their latched values from the ARB exit through the RESP exit.
REQ-026 WAIT: on mst_done, SHALL capture mst_nack and go to RESP; mst_done seen in any other state SHALL be ignored.
REQ-027 RESP (1 cycle): SHALL pulse done[idx] with nack valid; SHALL set rr_ptr to (idx+1) mod NUM_REQ; SHALL clear gnt on exit; next state IDLE.
REQ-028 Latency: with req rising in cycle 0 while IDLE, gnt SHALL be high from cycle 2 and mst_load SHALL pulse in cycle 3.
REQ-029 Changes to req or payload inputs after the ARB exit SHALL NOT affect the transaction in flight.
REQ-030 A requester that drops req during WAIT SHALL still receive its done pulse.
REQ-031 A requester still holding req after its done pulse SHALL be served again only after every other pending requester.

Reset
REQ-032 While rst is high, state SHALL be IDLE and rr_ptr 0.
REQ-033 While rst is high, gnt, done, nack, busy and mst_load SHALL be 0.
REQ-034 While rst is high, mst_rw, mst_dev, mst_reg and mst_data SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL abort it immediately with no done pulse.
REQ-036 After rst deasserts, arbitration SHALL resume from requester 0.

Configuration
REQ-037 Macro I2C_ARBITER_TIMEOUT_EN defined: a counter SHALL clear on WAIT entry and count each WAIT cycle.
REQ-038 With the macro defined, reaching TIMEOUT_CYCLES in WAIT without mst_done SHALL force RESP with nack=1.
REQ-039 Macro I2C_ARBITER_TIMEOUT_EN undefined: no counter SHALL be built, and WAIT SHALL persist until mst_done.

Verification
REQ-040 Single request: req=0001, dev=0x50, reg=0x10, data=0xA5, rw=0 -> mst_load 3 cycles after req; mst_dev=0x50, mst_reg=0x10, mst_data=0xA5; mst_done pulsed -> done=0001, nack=0.
REQ-041 Round robin: req=1111 held, every transaction acked -> grant order 0,1,2,3,0; each done pulse one cycle wide.
REQ-042 NACK path: requester 2, mst_nack=1 with mst_done -> done=0100, nack=1, rr_ptr=3.
REQ-043 Mid-flight reset: rst pulsed in WAIT -> gnt=0, busy=0, no done; next req=0010 served normally.
REQ-044 Timeout (macro defined, TIMEOUT_CYCLES=16): no mst_done -> done with nack=1 exactly 16 WAIT cycles after LAUNCH; with macro undefined, busy stays 1.
REQ-045 Payload change: requester 1 changes data 0x11 to 0x22 during WAIT -> mst_data stays 0x11 until RESP.
